// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and constants for the round-robin binary-to-Gray arbiter.
package gray_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Width of a requester index; never below one bit.
    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// Request/response bundle between requesters, consumer and the Gray arbiter.
// Handshake: a transfer happens on a rising clk edge where valid && ready.
interface gray_conv_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    localparam int ID_W = gray_arb_pkg::id_width(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_bin;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_gray;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;

    modport master (
        output req_valid, req_bin, rsp_ready,
        input  req_ready, rsp_valid, rsp_gray, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_bin, rsp_ready,
        output req_ready, rsp_valid, rsp_gray, rsp_id, busy
    );
endinterface

// File: rtl/gray_conv_arbiter_bin2gray.sv
// Pure-XOR binary to Gray conversion of one word.
module bin2gray_word #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    always_comb begin
        gray[WIDTH-1] = bin[WIDTH-1];
        for (int k = 0; k < WIDTH-1; k++) begin
            gray[k] = bin[k+1] ^ bin[k];
        end
    end
endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one bin2gray_word among N_REQ requesters;
// returns the registered Gray word tagged with the winner index.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    gray_conv_arbiter_if.slave  bus,
    output state_t              state_dbg
);
    localparam int              ID_W     = id_width(N_REQ);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   win_id;
    logic              win_found;
    logic              accept;
    logic [WIDTH-1:0]  win_bin;
    logic [WIDTH-1:0]  win_gray;
    logic [WIDTH-1:0]  gray_q;
    logic [ID_W-1:0]   id_q;

    // Search starts just after the last winner and wraps, so priority rotates.
    always_comb begin : rr_search
        int              cand;
        logic [ID_W-1:0] cand_id;
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        cand_id   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last_id) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_id = ID_W'(cand);
            if (!win_found && bus.req_valid[cand_id]) begin
                win_found = 1'b1;
                win_id    = cand_id;
            end
        end
    end

    // Gated by rst so req_ready is zero while reset is held.
    assign accept  = (state == IDLE) && win_found && !rst;
    assign win_bin = bus.req_bin[int'(win_id)*WIDTH +: WIDTH];

    bin2gray_word #(.WIDTH(WIDTH)) u_bin2gray (
        .bin  (win_bin),
        .gray (win_gray)
    );

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)        state_next = RESP;
            RESP: if (bus.rsp_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q  <= '0;
            id_q    <= '0;
            last_id <= LAST_RST;
        end else if (accept) begin
            gray_q  <= win_gray;
            id_q    <= win_id;
            last_id <= win_id;
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.busy      = (state == RESP);
    assign bus.rsp_gray  = gray_q;
    assign bus.rsp_id    = id_q;
    assign state_dbg     = state;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));

    a_no_grant_in_resp: assert property (@(posedge clk) disable iff (rst)
        (state == RESP) |-> (bus.req_ready == '0));

    a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.rsp_valid && !bus.rsp_ready) |=> ($stable(bus.rsp_gray) && $stable(bus.rsp_id)));

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: vector table plus multi-cycle sequences.
module tb_gray_conv_arbiter;
  import gray_arb_pkg::*;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;

  logic   clk;
  logic   rst;
  state_t state_dbg;

  gray_conv_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  gray_conv_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  typedef struct {
    logic [3:0]  req_valid;
    logic [15:0] req_bin;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_gray;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t       vecs[20];
  logic [3:0] gray_ref[16];
  logic [3:0] gray_rr[4];
  logic [5:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE: grant, one RESP cycle, handshake.
  task automatic run_vector(input vec_t v, input int idx);
    bus.req_valid = v.req_valid;
    bus.req_bin   = v.req_bin;
    #1;
    check($sformatf("vec%0d_ready", idx), 32'(bus.req_ready), 32'(v.exp_ready));
    tick();
    bus.req_valid = '0;
    check($sformatf("vec%0d_valid", idx), 32'(bus.rsp_valid), 32'd1);
    check($sformatf("vec%0d_busy", idx), 32'(bus.busy), 32'd1);
    check($sformatf("vec%0d_gray", idx), 32'(bus.rsp_gray), 32'(v.exp_gray));
    check($sformatf("vec%0d_id", idx), 32'(bus.rsp_id), 32'(v.exp_id));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check($sformatf("vec%0d_done", idx), 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_rdy;
    logic [5:0] exp_e;
    n_checks = 0;
    n_fail   = 0;

    gray_ref = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    gray_rr  = '{4'b0010, 4'b0111, 4'b1100, 4'b1001};

    // req_bin = {r3, r2, r1, r0}
    vecs[0] = '{req_valid: 4'b0100, req_bin: 16'h0B00, exp_ready: 4'b0100,
                exp_gray: 4'b1110, exp_id: 2'd2};
    for (int i = 0; i < 16; i++) begin
      vecs[1+i] = '{req_valid: 4'b0010, req_bin: {4'h5, 4'hA, 4'(i), 4'hF},
                    exp_ready: 4'b0010, exp_gray: gray_ref[i], exp_id: 2'd1};
    end
    vecs[17] = '{req_valid: 4'b1011, req_bin: 16'h63F1, exp_ready: 4'b1000,
                 exp_gray: 4'b0101, exp_id: 2'd3};
    vecs[18] = '{req_valid: 4'b1011, req_bin: 16'h63F9, exp_ready: 4'b0001,
                 exp_gray: 4'b1101, exp_id: 2'd0};
    vecs[19] = '{req_valid: 4'b1011, req_bin: 16'h63F9, exp_ready: 4'b0010,
                 exp_gray: 4'b1000, exp_id: 2'd1};

    // reset state, with requests pending while reset is held
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_bin   = 16'h0000;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_gray", 32'(bus.rsp_gray), 32'd0);
    check("rst_id", 32'(bus.rsp_id), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    bus.req_valid = '0;
    rst = 1'b0;
    #1;

    // table: single request, exhaustive data on requester 1, rotation
    for (int i = 0; i < 20; i++) begin
      run_vector(vecs[i], i);
    end

    // round-robin with all requesters valid and consumer always ready
    rst = 1'b1;
    #2;
    rst = 1'b0;
    bus.req_bin   = 16'hE853;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({2'(i % 4), gray_rr[i % 4]});
    end
    #1;
    check("rr_first_ready", 32'(bus.req_ready), 32'b0001);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k % 2 == 0) begin
        check($sformatf("rr%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
        check($sformatf("rr%0d_ready", k), 32'(bus.req_ready), 32'd0);
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            check($sformatf("rr%0d_unexpected", k), 32'd1, 32'd0);
          end else begin
            exp_e = exp_q.pop_front();
            check($sformatf("rr%0d_id_gray", k), 32'({bus.rsp_id, bus.rsp_gray}), 32'(exp_e));
          end
        end
      end else begin
        exp_rdy = 4'b0001 << ((k / 2 + 1) % 4);
        check($sformatf("rr%0d_valid", k), 32'(bus.rsp_valid), 32'd0);
        check($sformatf("rr%0d_ready", k), 32'(bus.req_ready), 32'(exp_rdy));
      end
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    check("rr_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // backpressure: last winner 0, so requester 2 alone wins
    bus.req_bin   = 16'h0700;
    bus.req_valid = 4'b0100;
    #1;
    check("bp_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = 4'b1111;
    #1;
    check("bp_rise_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_rise_gray", 32'(bus.rsp_gray), 32'b0100);
    check("bp_rise_id", 32'(bus.rsp_id), 32'd2);
    check("bp_rise_ready", 32'(bus.req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("bp%0d_valid", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d_gray", c), 32'(bus.rsp_gray), 32'b0100);
      check($sformatf("bp%0d_id", c), 32'(bus.rsp_id), 32'd2);
      check($sformatf("bp%0d_ready", c), 32'(bus.req_ready), 32'd0);
      check($sformatf("bp%0d_busy", c), 32'(bus.busy), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_hs_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_after_busy", 32'(bus.busy), 32'd0);
    check("bp_after_ready", 32'(bus.req_ready), 32'b1000);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();

    // asynchronous reset mid-cycle while in RESP
    bus.req_bin   = 16'h90C5;
    bus.req_valid = 4'b0010;
    #1;
    check("ar_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = 4'b1001;
    check("ar_pre_valid", 32'(bus.rsp_valid), 32'd1);
    check("ar_pre_id", 32'(bus.rsp_id), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(bus.rsp_valid), 32'd0);
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_req_ready", 32'(bus.req_ready), 32'd0);
    check("ar_gray", 32'(bus.rsp_gray), 32'd0);
    check("ar_id", 32'(bus.rsp_id), 32'd0);
    check("ar_state", 32'(state_dbg), 32'(IDLE));
    #1;
    rst = 1'b0;
    #1;
    check("ar_release_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    check("ar_grant_valid", 32'(bus.rsp_valid), 32'd1);
    check("ar_grant_id", 32'(bus.rsp_id), 32'd0);
    check("ar_grant_gray", 32'(bus.rsp_gray), 32'b0111);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("ar_done", 32'(bus.rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Round-robin arbiter and sequencer that shares one binary-to-Gray conversion datapath among `N_REQ` requesters. Each requester offers a binary word over a valid/ready handshake. The block grants one requester at a time and converts its word. It returns the registered Gray result, tagged with the requester index, over a downstream valid/ready handshake. It sits between pointer/counter producers (e.g. FIFO write/read pointer logic) and consumers that need Gray-coded values.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 4: data word width, ≥2.

Ports:
- `clk` — input, 1 bit: single clock, rising edge.
- `rst` — input, 1 bit: reset, asynchronous, active-high.
- `req_valid` — input, `N_REQ` bits: per-requester valid.
- `req_ready` — output, `N_REQ` bits: per-requester accept, one-hot or zero.
- `req_bin` — input, `N_REQ*WIDTH` bits: requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `rsp_valid` — output, 1 bit: result available.
- `rsp_ready` — input, 1 bit: consumer accepts result.
- `rsp_gray` — output, `WIDTH` bits: Gray code of the granted word.
- `rsp_id` — output, `$clog2(N_REQ)` bits: index of the granted requester.
- `busy` — output, 1 bit: high while in state RESP.

## Operation
- FSM, two states: IDLE, RESP.
- **IDLE:**
  - If any `req_valid`, select the winner i by round-robin. Search order starts at `last_id+1` modulo `N_REQ` and wraps.
  - Drive `req_ready[i]=1` combinationally in the same cycle. All other `req_ready` bits are 0.
  - At the clock edge:
    - capture `rsp_gray <= bin ^ (bin >> 1)`;
    - capture `rsp_id <= i`;
    - set `last_id <= i`;
    - go to RESP.
  - If no `req_valid` is asserted, stay in IDLE. Outputs hold their previous values.
- **RESP:**
  - `rsp_valid=1`. `req_ready` is all zero.
  - `rsp_gray` and `rsp_id` stay stable until the handshake.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - No new request is accepted in the same cycle as the handshake.
- Conversion is pure XOR with no arithmetic.
  - MSB of `rsp_gray` equals MSB of `bin`.
  - Bit k equals `bin[k+1]^bin[k]`.
- The arbiter never inspects `req_bin` of non-granted requesters.
- Requesters must hold `req_valid` and `req_bin` stable until their `req_ready` is seen. A requester dropping `req_valid` before grant is legal; it simply loses its turn.
- **Reset**, asynchronous, at any time:
  - state=IDLE; `rsp_valid=0`; `req_ready=0`; `busy=0`;
  - `rsp_gray=0`; `rsp_id=0`;
  - `last_id=N_REQ-1`, so requester 0 has priority at the first grant.
  - A pending result is discarded.

## Timing
- Grant and accept happen in the same cycle as `req_valid` while in IDLE.
- `rsp_valid` rises exactly 1 cycle after the accept edge.
- Minimum 2 cycles per transaction; maximum throughput is 1 result per 2 cycles.
- Fairness: with all requesters continuously valid and `rsp_ready=1`, each requester is granted once every `2*N_REQ` cycles.
- `rsp_valid` deasserts on the edge following the handshake.
- `req_ready` depends combinationally on `req_valid`, state and `last_id`.
- All other outputs are registered.

## Structure
- Shared package `gray_arb_pkg` holds:
  - the state typedef (IDLE, RESP);
  - the ID width constant/function derived from `N_REQ`.
- One combinational sub-module `bin2gray_word` (parameter `WIDTH`, `bin` → `gray`), instantiated once on the muxed winner word.
- Round-robin priority search is a local loop inside `gray_conv_arbiter`.

## Test plan
- **Single request:** after reset, `N_REQ=4`, `WIDTH=4`, `req_valid=4'b0100` with word 4'b1011.
  - Expect `req_ready=4'b0100` in the same cycle.
  - Next cycle: `rsp_valid=1`, `rsp_gray=4'b1110`, `rsp_id=2`.
- **Round-robin:** `req_valid=4'b1111` held, `rsp_ready=1`.
  - Grant order 0,1,2,3,0.
  - Each `rsp_valid` pulse lasts 1 cycle, spaced 2 cycles apart.
- **Backpressure:** `rsp_ready=0` for 3 cycles after `rsp_valid` rises.
  - `rsp_gray`/`rsp_id` stay stable.
  - `req_ready=0` throughout.
  - Handshake on cycle 4, then IDLE.
- **Exhaustive data:** requester 1 issues 0..15 in sequence.
  - `rsp_gray` must equal 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000.
- **Reset mid-operation:** assert `rst` asynchronously mid-cycle while in RESP.
  - `rsp_valid`, `busy` and `req_ready` drop immediately.
  - After release with `req_valid=4'b1001`, requester 0 is granted first.
